// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, bus ACK/NACK levels and R/W bit encoding.
// Also imported by the companion master.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAckAddr,
    StRxData,
    StAckRx,
    StTxData,
    StWaitAckTx
  } i2c_state_e;

  localparam logic       LP_ACK      = 1'b0;
  localparam logic       LP_NACK     = 1'b1;
  localparam logic       LP_RW_WRITE = 1'b0;
  localparam logic       LP_RW_READ  = 1'b1;
  localparam logic [2:0] LP_CNT_MSB  = 3'd7;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line, followed by a single edge-detect flop.
module i2c_sync_edge #(
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic iw_clk,
  input  logic iw_reset,
  input  logic iw_din,
  output logic ow_level,
  output logic ow_rise,
  output logic ow_fall
);

  logic [P_SYNC_STAGES-1:0] r_sync;
  logic                     r_prev;

  // Flops reset to 1 so an idle (pulled-up) bus produces no spurious edge.
  always_ff @(posedge iw_clk) begin
    if (iw_reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync[0] <= iw_din;
      for (int i = 1; i < int'(P_SYNC_STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[P_SYNC_STAGES-1];
    end
  end

  assign ow_level = r_sync[P_SYNC_STAGES-1];
  assign ow_rise  = ow_level & ~r_prev;
  assign ow_fall  = ~ow_level & r_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with a fixed 7-bit address: byte receive on writes, byte transmit on reads.
// Oversamples SCL/SDA on iw_clk; never drives SCL.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  P_ADDR        = 7'h42,
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic       iw_clk,
  input  logic       iw_reset,
  input  logic       iw_i2c_scl,
  inout  wire        io_i2c_sda,
  input  logic [7:0] iw_tx_data,
  output logic       ow_tx_req,
  output logic [7:0] ow_rx_data,
  output logic       ow_rx_valid,
  output logic       ow_busy,
  output logic       ow_ready
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_sync_edge #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_sync_scl (
    .iw_clk  (iw_clk),
    .iw_reset(iw_reset),
    .iw_din  (iw_i2c_scl),
    .ow_level(w_scl),
    .ow_rise (w_scl_rise),
    .ow_fall (w_scl_fall)
  );

  i2c_sync_edge #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_sync_sda (
    .iw_clk  (iw_clk),
    .iw_reset(iw_reset),
    .iw_din  (io_i2c_sda),
    .ow_level(w_sda),
    .ow_rise (w_sda_rise),
    .ow_fall (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_state_e r_state, w_state_d;
  logic [2:0] r_cnt, w_cnt_d;
  logic [7:0] r_shift, w_shift_d;
  logic [7:0] r_rx_data, w_rx_data_d;
  logic       r_sda_oe, w_sda_oe_d;
  logic       r_rw, w_rw_d;
  logic       r_ack_seen, w_ack_seen_d;
  logic       r_rx_valid, w_rx_valid_d;
  logic       r_tx_req, w_tx_req_d;
  logic       r_busy, w_busy_d;

  always_ff @(posedge iw_clk) begin
    if (iw_reset) begin
      r_state    <= StIdle;
      r_cnt      <= LP_CNT_MSB;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_sda_oe   <= 1'b0;
      r_rw       <= 1'b0;
      r_ack_seen <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_shift    <= w_shift_d;
      r_rx_data  <= w_rx_data_d;
      r_sda_oe   <= w_sda_oe_d;
      r_rw       <= w_rw_d;
      r_ack_seen <= w_ack_seen_d;
      r_rx_valid <= w_rx_valid_d;
      r_tx_req   <= w_tx_req_d;
      r_busy     <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_shift_d    = r_shift;
    w_rx_data_d  = r_rx_data;
    w_sda_oe_d   = r_sda_oe;
    w_rw_d       = r_rw;
    w_ack_seen_d = r_ack_seen;
    w_rx_valid_d = 1'b0;
    w_tx_req_d   = 1'b0;
    w_busy_d     = r_busy;

    if (w_start) begin
      w_state_d    = StAddr;
      w_cnt_d      = LP_CNT_MSB;
      w_sda_oe_d   = 1'b0;
      w_ack_seen_d = 1'b0;
    end else if (w_stop) begin
      w_state_d  = StIdle;
      w_sda_oe_d = 1'b0;
      w_busy_d   = 1'b0;
    end else begin
      case (r_state)
        StAddr: begin
          if (w_scl_rise) begin
            w_shift_d = {r_shift[6:0], w_sda};
            if (r_cnt == 3'd0) begin
              if (r_shift[6:0] == P_ADDR) begin
                w_state_d = StAckAddr;
                w_rw_d    = w_sda;
                w_busy_d  = 1'b1;
              end else begin
                w_state_d = StIdle;
                w_busy_d  = 1'b0;
              end
            end else begin
              w_cnt_d = r_cnt - 3'd1;
            end
          end
        end

        // ACK states see two falls: the first asserts ACK, the second (9th) ends it.
        // r_sda_oe is always low on entry, so it doubles as the phase marker.
        StAckAddr: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_d = 1'b1;
            end else if (r_rw == LP_RW_READ) begin
              w_shift_d  = iw_tx_data;
              w_tx_req_d = 1'b1;
              w_sda_oe_d = ~iw_tx_data[7];
              w_cnt_d    = LP_CNT_MSB;
              w_state_d  = StTxData;
            end else begin
              w_sda_oe_d = 1'b0;
              w_cnt_d    = LP_CNT_MSB;
              w_state_d  = StRxData;
            end
          end
        end

        StRxData: begin
          if (w_scl_rise) begin
            w_shift_d = {r_shift[6:0], w_sda};
            if (r_cnt == 3'd0) begin
              w_rx_data_d  = {r_shift[6:0], w_sda};
              w_rx_valid_d = 1'b1;
              w_state_d    = StAckRx;
            end else begin
              w_cnt_d = r_cnt - 3'd1;
            end
          end
        end

        StAckRx: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_d = 1'b1;
            end else begin
              w_sda_oe_d = 1'b0;
              w_cnt_d    = LP_CNT_MSB;
              w_state_d  = StRxData;
            end
          end
        end

        // Bit 7 was put on the line at load; each later fall shifts out the next bit.
        StTxData: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_oe_d   = 1'b0;
              w_ack_seen_d = 1'b0;
              w_state_d    = StWaitAckTx;
            end else begin
              w_shift_d  = {r_shift[6:0], 1'b0};
              w_sda_oe_d = ~r_shift[6];
              w_cnt_d    = r_cnt - 3'd1;
            end
          end
        end

        StWaitAckTx: begin
          if (w_scl_rise) begin
            if (w_sda == LP_ACK) begin
              w_ack_seen_d = 1'b1;
            end else begin
              w_state_d = StIdle;
              w_busy_d  = 1'b0;
            end
          end else if (w_scl_fall && r_ack_seen) begin
            w_ack_seen_d = 1'b0;
            w_shift_d    = iw_tx_data;
            w_tx_req_d   = 1'b1;
            w_sda_oe_d   = ~iw_tx_data[7];
            w_cnt_d      = LP_CNT_MSB;
            w_state_d    = StTxData;
          end
        end

        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  assign io_i2c_sda  = r_sda_oe ? 1'b0 : 1'bz;
  assign ow_tx_req   = r_tx_req;
  assign ow_rx_data  = r_rx_data;
  assign ow_rx_valid = r_rx_valid;
  assign ow_busy     = r_busy;
  assign ow_ready    = (r_state == StIdle) && !iw_reset;

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter P_ADDR, default 7'h42, the 7-bit slave address this block responds to.
REQ-002 SHALL have parameter P_SYNC_STAGES, default 2, the synchronizer depth on SCL and SDA.
REQ-003 iw_clk  input  1  system clock; one clock; must be at least 8x the SCL frequency.
REQ-004 iw_reset  input  1  reset, synchronous and active-high.
REQ-005 iw_i2c_scl  input  1  bus clock from master; this block never drives SCL and never clock-stretches.
REQ-006 io_i2c_sda  inout  1  open-drain data line; the block drives only 0 or Z, with pull-up external.
REQ-007 iw_tx_data  input  8  byte returned to the master on a read; sampled at load points.
REQ-008 ow_tx_req  output  1  one-cycle pulse when iw_tx_data has been loaded; the next byte must be valid before the next load.
REQ-009 ow_rx_data  output  8  last byte written by the master; held until the next write byte.
REQ-010 ow_rx_valid  output  1  one-cycle pulse when ow_rx_data updates.
REQ-011 ow_busy  output  1  high from an addressed START until STOP or NACK release.
REQ-012 ow_ready  output  1  high when state==IDLE and reset is low.

Function
REQ-013 SCL and SDA SHALL pass through P_SYNC_STAGES flops, then one edge-detect flop.
REQ-014 START SHALL be detected when synced SDA falls while synced SCL is high; STOP when synced SDA rises while synced SCL is high.
REQ-015 START and repeated START SHALL be accepted in any state: count reset to 7, state to ADDR, SDA released.
REQ-016 STOP SHALL be accepted in any state: state to IDLE, SDA released, ow_busy low the next cycle.
REQ-017 States: IDLE, ADDR, ACK_ADDR, RX_DATA, ACK_RX, TX_DATA, WAIT_ACK_TX.
REQ-018 Input bits SHALL be sampled on the synced SCL rising edge, MSB first.
REQ-019 Output changes on SDA (ACK assert/release, TX bits) SHALL occur on the synced SCL falling edge only.
REQ-020 ADDR: after 8 bits, if addr==P_ADDR go to ACK_ADDR and drive SDA=0 from the next SCL fall through the 9th SCL fall; otherwise go to IDLE and do not drive.
REQ-021 ACK_ADDR with rw=0: go to RX_DATA with count=7.
REQ-022 ACK_ADDR with rw=1: load iw_tx_data into the shift register and pulse ow_tx_req on the 9th SCL fall; drive bit 7 at that same fall; go to TX_DATA.
REQ-023 RX_DATA: after the 8th sampled bit, ow_rx_data updates and ow_rx_valid pulses exactly 1 cycle after that edge is detected; go to ACK_RX, which drives ACK as in REQ-020, then returns to RX_DATA. The write byte count is unlimited.
REQ-024 TX_DATA: drive 0 for a 0 bit and release for a 1 bit; after 8 bits release SDA and go to WAIT_ACK_TX.
REQ-025 WAIT_ACK_TX: sample SDA at the 9th rise. If 0 (ACK), reload and pulse ow_tx_req at the next fall and go to TX_DATA. If 1 (NACK), go to IDLE; ow_busy drops.
REQ-026 The bit counter SHALL be 3 bits and must not wrap mid-byte; 8 bits per byte exactly.
REQ-027 Simultaneous START detect and SCL edge in one cycle: START SHALL win.

Reset
REQ-028 On reset: state IDLE, SDA released (Z), ow_rx_data=0, ow_rx_valid=0, ow_tx_req=0, ow_busy=0, synchronizer flops=1.
REQ-029 Reset asserted mid-transaction SHALL release SDA on the next iw_clk edge and ignore the bus until the next START.

Structure
REQ-030 Package i2c_pkg SHALL hold the state constants, the ACK/NACK levels, and the R/W bit encoding, shared with the master.
REQ-031 One sub-module, i2c_sync_edge (synchronizer + rise/fall detect), SHALL be instantiated once per line.

Verification
REQ-032 Write 0x42/W then 0xA5: ACK on both 9th clocks; ow_rx_data=0xA5; exactly one ow_rx_valid pulse.
REQ-033 Address 0x43/W: SDA never driven low; no ow_rx_valid pulse; ow_busy stays 0.
REQ-034 Read 0x42/R with iw_tx_data=0x3C, master NACK: SDA carries 0,0,1,1,1,1,0,0; one ow_tx_req pulse; state IDLE afterwards.
REQ-035 Read 2 bytes (0x3C then 0xC3) with master ACK then NACK: two ow_tx_req pulses; second byte on SDA = 0xC3.
REQ-036 Repeated START after writing 0x11, then read: ow_rx_data=0x11, then TX begins without an intervening STOP.
REQ-037 Reset asserted at TX bit 4 while driving 0: SDA=Z within 1 cycle; STOP then a new write of 0x5A is received correctly.
